snake_engine: RTL
=================

Name: snake_engine

Overview:
- Parametrised snake-state engine that replaces the fixed-size Snake module.
- Holds a shift-register array of up to MAX_LEN grid-cell segments.
- Steps the snake on an internal move tick, latches direction from keyboard pulses and grows on cherry events.
- Detects wall and self collisions and answers per-pixel head/body queries for Screen.

Parameters:
- GRID_W, 40, grid width in cells.
- GRID_H, 30, grid height in cells.
- X_BITS, 6, cell x-coordinate width.
- Y_BITS, 5, cell y-coordinate width.
- CELL_BITS, 4, log2 of cell size in pixels (cell = pixel >> CELL_BITS).
- MAX_LEN, 32, maximum segment count (>= INIT_LEN + 1).
- INIT_LEN, 3, length after reset or re-arm (>= 2).
- TICK_DIV, 5000000, clk cycles per move step.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  game running (driven by gameStart); low = hold initial snake.
- Up, Down, Left, Right  in  1 each  keyboard direction pulses/levels.
- grow  in  1  cherry-eaten pulse.
- pixel_x  in  10  VGA query x.
- pixel_y  in  10  VGA query y.
- snakeHead  out  1  queried pixel lies in the head cell (registered).
- snakeBody  out  1  queried pixel lies in a body cell (registered).
- bump  out  1  collision occurred (sticky).
- move_tick  out  1  one-cycle pulse on each executed step.
- head_x  out  X_BITS  head cell x.
- head_y  out  Y_BITS  head cell y.
- length  out  $clog2(MAX_LEN+1)  current segment count.

Behaviour:
- Reset/re-arm (rst high async, or enable low sync):
  - seg[0] = (GRID_W/2, GRID_H/2); seg[i] = (GRID_W/2 - i, GRID_H/2).
  - length = INIT_LEN, dir = RIGHT, grow_pend = 0, tick counter = 0, state = IDLE.
  - bump, move_tick, snakeHead, snakeBody = 0.
- States:
  - IDLE -> RUN when enable = 1.
  - RUN -> DEAD on collision.
  - Any state -> IDLE when enable = 0.
  - DEAD holds all positions frozen with bump = 1.
- Tick: the counter runs only in RUN, counting 0..TICK_DIV-1; the step executes in the cycle the count is TICK_DIV-1, then the counter returns to 0.
- Direction:
  - next_dir is sampled every cycle.
  - Priority when several keys are active: Up > Down > Left > Right.
  - A key opposite to the direction of the last executed step is ignored, so two quick keys cannot reverse the snake.
  - dir takes next_dir at the step.
- Grow:
  - A grow pulse sets grow_pend. grow in the same cycle as a step counts for that step.
  - At the step, if grow_pend = 1 and length < MAX_LEN: shift without dropping the tail, length + 1.
  - At MAX_LEN the grow is discarded.
  - grow_pend clears on every step.
- Step computation:
  - Candidate head = seg[0] +/- 1 along dir.
  - Wall collision: x = 0 moving left, x = GRID_W-1 moving right, y = 0 moving up, or y = GRID_H-1 moving down.
  - Self collision: candidate equals seg[i] for i in 0..length-2 when not growing, or 0..length-1 when growing. Moving into the vacating tail cell is legal.
  - On collision: no shift, bump = 1, state = DEAD, no move_tick.
  - Otherwise: seg[i] <= seg[i-1], seg[0] <= candidate, move_tick = 1 for one cycle.
- Query:
  - cell = (pixel_x >> CELL_BITS, pixel_y >> CELL_BITS).
  - snakeHead = (cell == seg[0]).
  - snakeBody = cell matches any seg[i] with 1 <= i < length.
  - Both outputs are 0 when the cell is outside the grid. Latency is 1 clk.
- Segments at index >= length are don't-care and never match.

Test Plan:
All scenarios use GRID_W = GRID_H = 8, MAX_LEN = 6, INIT_LEN = 3, TICK_DIV = 4, CELL_BITS = 4. Initial snake: head (4,4), body (3,4),(2,4).
- Wall: enable, no keys -> heads (5,4),(6,4),(7,4) at ticks 1-3. Tick 4 -> bump = 1, DEAD, head stays (7,4), no move_tick.
- Reversal: press Left while moving Right -> next head (5,4). Then press Up -> head (5,3). Left then Down within one tick period -> Down ignored, head moves Left.
- Grow/saturation: grow pulse before tick -> length 4, tail (2,4) kept. Four more grows -> length stays at 6.
- Tail chase: at length 4 (head (4,4), body (3,4),(2,4),(1,4)), step Up, Left, Down -> head (3,4) equals old tail, no bump. Same path with grow on the last step -> bump = 1.
- Query: pixel (72,72) -> snakeHead = 1 one cycle later. Pixel (40,72) -> snakeBody = 1. Pixel (200,10) -> both 0.
- Reset mid-run: assert rst asynchronously mid-tick -> outputs clear immediately, initial snake restored, IDLE. Dropping enable in DEAD -> IDLE with bump = 0.

Source files
------------

// File: rtl/snake_if.sv
// Snake engine bus: game control, keyboard, cherry and pixel-query signals.
// master = game/screen side, slave = snake_engine.
interface snake_if #(
    parameter int X_BITS = 6,
    parameter int Y_BITS = 5,
    parameter int LEN_W  = 6
);
    logic              enable;
    logic              Up;
    logic              Down;
    logic              Left;
    logic              Right;
    logic              grow;
    logic [9:0]        pixel_x;
    logic [9:0]        pixel_y;
    logic              snakeHead;
    logic              snakeBody;
    logic              bump;
    logic              move_tick;
    logic [X_BITS-1:0] head_x;
    logic [Y_BITS-1:0] head_y;
    logic [LEN_W-1:0]  length;

    modport master (
        output enable, Up, Down, Left, Right, grow, pixel_x, pixel_y,
        input  snakeHead, snakeBody, bump, move_tick, head_x, head_y, length
    );

    modport slave (
        input  enable, Up, Down, Left, Right, grow, pixel_x, pixel_y,
        output snakeHead, snakeBody, bump, move_tick, head_x, head_y, length
    );
endinterface

// File: rtl/snake_engine.sv
// Parametrised snake-state engine: segment shift register, tick-driven
// stepping, direction latch, growth, collision detection and pixel query.
module snake_engine #(
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30,
    parameter int X_BITS    = 6,
    parameter int Y_BITS    = 5,
    parameter int CELL_BITS = 4,
    parameter int MAX_LEN   = 32,
    parameter int INIT_LEN  = 3,
    parameter int TICK_DIV  = 5000000
) (
    input logic    clk,
    input logic    rst,
    snake_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    state_t            state_q, state_d;
    dir_t              dir_q, dir_d;
    dir_t              next_dir_q, next_dir_d;
    dir_t              key_dir;
    logic [X_BITS-1:0] seg_x_q [MAX_LEN];
    logic [X_BITS-1:0] seg_x_d [MAX_LEN];
    logic [Y_BITS-1:0] seg_y_q [MAX_LEN];
    logic [Y_BITS-1:0] seg_y_d [MAX_LEN];
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              grow_pend_q, grow_pend_d;
    logic              bump_q, bump_d;
    logic              tick_q, tick_d;
    logic              head_q, head_d;
    logic              body_q, body_d;

    logic [X_BITS-1:0] cand_x;
    logic [Y_BITS-1:0] cand_y;
    logic              wall;
    logic              self_hit;
    logic              grow_eff;
    logic [9:0]        cell_x;
    logic [9:0]        cell_y;
    logic              in_grid;

    function automatic dir_t opposite(input dir_t d);
        dir_t r;
        case (d)
            DIR_UP:   r = DIR_DOWN;
            DIR_DOWN: r = DIR_UP;
            DIR_LEFT: r = DIR_RIGHT;
            default:  r = DIR_LEFT;
        endcase
        return r;
    endfunction

    function automatic logic [X_BITS-1:0] init_x(input int i);
        return X_BITS'(GRID_W / 2 - i);
    endfunction

    // Prioritised key decode; a key reversing the last step is dropped
    always_comb begin
        key_dir = next_dir_q;
        if (bus.Up)         key_dir = DIR_UP;
        else if (bus.Down)  key_dir = DIR_DOWN;
        else if (bus.Left)  key_dir = DIR_LEFT;
        else if (bus.Right) key_dir = DIR_RIGHT;
        if (key_dir == opposite(dir_q)) key_dir = next_dir_q;
    end

    // Candidate head, wall test and self test for a step along key_dir
    always_comb begin
        cand_x = seg_x_q[0];
        cand_y = seg_y_q[0];
        wall   = 1'b0;
        case (key_dir)
            DIR_UP: begin
                wall   = (seg_y_q[0] == '0);
                cand_y = seg_y_q[0] - Y_BITS'(1);
            end
            DIR_DOWN: begin
                wall   = (seg_y_q[0] == Y_BITS'(GRID_H - 1));
                cand_y = seg_y_q[0] + Y_BITS'(1);
            end
            DIR_LEFT: begin
                wall   = (seg_x_q[0] == '0);
                cand_x = seg_x_q[0] - X_BITS'(1);
            end
            default: begin
                wall   = (seg_x_q[0] == X_BITS'(GRID_W - 1));
                cand_x = seg_x_q[0] + X_BITS'(1);
            end
        endcase
        grow_eff = (grow_pend_q | bus.grow) && (len_q < LEN_W'(MAX_LEN));
        self_hit = 1'b0;
        // The tail cell is vacated unless the snake grows on this step
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((i < int'(len_q) - 1 || (grow_eff && i < int'(len_q))) &&
                seg_x_q[i] == cand_x && seg_y_q[i] == cand_y)
                self_hit = 1'b1;
        end
    end

    // Next-state, step execution, query match and re-arm
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        next_dir_d  = key_dir;
        seg_x_d     = seg_x_q;
        seg_y_d     = seg_y_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        grow_pend_d = grow_pend_q;
        bump_d      = bump_q;
        tick_d      = 1'b0;

        cell_x  = bus.pixel_x >> CELL_BITS;
        cell_y  = bus.pixel_y >> CELL_BITS;
        in_grid = (cell_x < 10'(GRID_W)) && (cell_y < 10'(GRID_H));
        head_d  = in_grid && cell_x == 10'(seg_x_q[0]) &&
                  cell_y == 10'(seg_y_q[0]);
        body_d  = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (in_grid && i < int'(len_q) &&
                cell_x == 10'(seg_x_q[i]) && cell_y == 10'(seg_y_q[i]))
                body_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.enable) state_d = RUN;
            end
            RUN: begin
                grow_pend_d = grow_pend_q | bus.grow;
                if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
                    cnt_d       = '0;
                    grow_pend_d = 1'b0;
                    if (wall || self_hit) begin
                        bump_d  = 1'b1;
                        state_d = DEAD;
                    end else begin
                        for (int i = 1; i < MAX_LEN; i++) begin
                            seg_x_d[i] = seg_x_q[i-1];
                            seg_y_d[i] = seg_y_q[i-1];
                        end
                        seg_x_d[0] = cand_x;
                        seg_y_d[0] = cand_y;
                        if (grow_eff) len_d = len_q + LEN_W'(1);
                        dir_d  = key_dir;
                        tick_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = DEAD;
            end
        endcase

        if (!bus.enable) begin
            state_d     = IDLE;
            dir_d       = DIR_RIGHT;
            next_dir_d  = DIR_RIGHT;
            len_d       = LEN_W'(INIT_LEN);
            cnt_d       = '0;
            grow_pend_d = 1'b0;
            bump_d      = 1'b0;
            tick_d      = 1'b0;
            head_d      = 1'b0;
            body_d      = 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_d[i] = init_x(i);
                seg_y_d[i] = Y_BITS'(GRID_H / 2);
            end
        end
    end

    // State and segment registers with asynchronous reset to the initial snake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dir_q       <= DIR_RIGHT;
            next_dir_q  <= DIR_RIGHT;
            len_q       <= LEN_W'(INIT_LEN);
            cnt_q       <= '0;
            grow_pend_q <= 1'b0;
            bump_q      <= 1'b0;
            tick_q      <= 1'b0;
            head_q      <= 1'b0;
            body_q      <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= Y_BITS'(GRID_H / 2);
            end
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            next_dir_q  <= next_dir_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            grow_pend_q <= grow_pend_d;
            bump_q      <= bump_d;
            tick_q      <= tick_d;
            head_q      <= head_d;
            body_q      <= body_d;
            seg_x_q     <= seg_x_d;
            seg_y_q     <= seg_y_d;
        end
    end

    assign bus.snakeHead = head_q;
    assign bus.snakeBody = body_q;
    assign bus.bump      = bump_q;
    assign bus.move_tick = tick_q;
    assign bus.head_x    = seg_x_q[0];
    assign bus.head_y    = seg_y_q[0];
    assign bus.length    = len_q;
endmodule
